// File: rtl/mem_port_arbiter.sv
// Round-robin burst arbiter: grants one requester at a time for req_len+1 beats.
// Optional watchdog that aborts a stalled burst is enabled with `define ARB_WATCHDOG_EN.
module mem_port_arbiter #(
  parameter int unsigned CTRL_WIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CTRL_WIDTH-1:0]           req,
  input  logic [CTRL_WIDTH*LEN_WIDTH-1:0] req_len,
  input  logic                            beat_valid,
  output logic [CTRL_WIDTH-1:0]           grant,
  output logic [$clog2(CTRL_WIDTH)-1:0]   grant_idx,
  output logic                            busy,
  output logic [CTRL_WIDTH-1:0]           done
`ifdef ARB_WATCHDOG_EN
  ,
  output logic                            timeout
`endif
);

  localparam int unsigned IdxW = $clog2(CTRL_WIDTH);

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e               state_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [LEN_WIDTH-1:0] len_q;

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WdW-1:0] wd_q;
`endif

  logic                  win_found;
  logic [IdxW-1:0]       win_idx;
  logic [CTRL_WIDTH-1:0] win_onehot;
  logic [LEN_WIDTH-1:0]  win_len;

  // Search above the pointer first, then wrap to the bottom (pointer itself comes last).
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_len    = '0;
    for (int i = 0; i < int'(CTRL_WIDTH); i++) begin
      if (!win_found && req[i] && (i > int'(grant_idx))) begin
        win_found = 1'b1;
        win_idx   = IdxW'(i);
      end
    end
    for (int i = 0; i < int'(CTRL_WIDTH); i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(i);
      end
    end
    for (int i = 0; i < int'(CTRL_WIDTH); i++) begin
      if (IdxW'(i) == win_idx) begin
        win_onehot[i] = 1'b1;
        win_len       = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
      done      <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
`ifdef ARB_WATCHDOG_EN
      timeout   <= 1'b0;
      wd_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= '0;
          if (win_found) begin
            state_q   <= StGrant;
            grant     <= win_onehot;
            grant_idx <= win_idx;
            busy      <= 1'b1;
            len_q     <= win_len;
            cnt_q     <= '0;
`ifdef ARB_WATCHDOG_EN
            wd_q      <= '0;
`endif
          end
        end
        StGrant: begin
          if (beat_valid) begin
            if (cnt_q == len_q) begin
              state_q <= StRelease;
              done    <= grant;
              grant   <= '0;
              busy    <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
`ifdef ARB_WATCHDOG_EN
            wd_q <= '0;
          end else if (wd_q == WdW'(TIMEOUT - 1)) begin
            // Stalled burst is abandoned without a completion pulse.
            state_q <= StRelease;
            grant   <= '0;
            busy    <= 1'b0;
            timeout <= 1'b1;
            cnt_q   <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
`endif
          end
        end
        StRelease: begin
          state_q <= StIdle;
          done    <= '0;
`ifdef ARB_WATCHDOG_EN
          timeout <= 1'b0;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a burst-level reference model.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int LW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*LW-1:0] req_len = '0;
  logic            beat_valid = 1'b0;
  logic [N-1:0]    grant;
  logic [1:0]      grant_idx;
  logic            busy;
  logic [N-1:0]    done;
`ifdef ARB_WATCHDOG_EN
  logic            timeout;
`endif

  mem_port_arbiter #(
    .CTRL_WIDTH (N),
    .LEN_WIDTH  (LW),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_len    (req_len),
    .beat_valid (beat_valid),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .done       (done)
`ifdef ARB_WATCHDOG_EN
    ,
    .timeout    (timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: owner of the current burst, beats still owed, round-robin pointer.
  int           m_owner;
  int           m_left;
  int           m_ptr;
  int           m_wd;
  bit           m_rel;
  bit           m_to;
  logic [N-1:0] m_done;

  function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_ptr   = 0;
    m_wd    = 0;
    m_rel   = 1'b0;
    m_to    = 1'b0;
    m_done  = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] nd;
    bit           nt;
    int           w;
    nd = '0;
    nt = 1'b0;
    if (m_rel) begin
      m_rel = 1'b0;
    end else if (m_owner >= 0) begin
      if (beat_valid) begin
        m_left--;
        m_wd = 0;
        if (m_left == 0) begin
          nd[m_owner] = 1'b1;
          m_owner     = -1;
          m_rel       = 1'b1;
        end
      end
`ifdef ARB_WATCHDOG_EN
      else if (m_wd == TO - 1) begin
        nt      = 1'b1;
        m_owner = -1;
        m_rel   = 1'b1;
      end else begin
        m_wd++;
      end
`endif
    end else begin
      w = rr_pick(m_ptr, req);
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = w;
        m_left  = int'(req_len[w*LW +: LW]) + 1;
        m_wd    = 0;
      end
    end
    m_done = nd;
    m_to   = nt;
  endtask

  task automatic compare_outputs();
    logic [31:0] exp_grant;
    exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check_eq("grant", 32'(grant), exp_grant);
    check_eq("grant_idx", 32'(grant_idx), 32'(m_ptr));
    check_eq("busy", 32'(busy), 32'(m_owner >= 0));
    check_eq("done", 32'(done), 32'(m_done));
`ifdef ARB_WATCHDOG_EN
    check_eq("timeout", 32'(timeout), 32'(m_to));
`endif
  endtask

  // Per cycle: check at negedge, drive new inputs, advance model at posedge.
  task automatic run_cycles(input int n, input int beat_pct, input int req_pct,
                            input int len_max, input int rst_permille);
    for (int cyc = 0; cyc < n; cyc++) begin
      @(negedge clk);
      compare_outputs();
      for (int i = 0; i < N; i++) begin
        req[i] = ($urandom_range(0, 99) < req_pct);
        req_len[i*LW +: LW] = LW'($urandom_range(0, len_max));
      end
      beat_valid = ($urandom_range(0, 99) < beat_pct);
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if (m_owner >= 0 && $urandom_range(0, 999) < rst_permille) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_grant_idx", 32'(grant_idx), 32'd0);
        model_reset();
      end
      @(posedge clk);
      if (rst_n) model_step();
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare_outputs();
    @(negedge clk);
    compare_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    run_cycles(600, 60, 40, 3, 0);
    run_cycles(300, 100, 100, 0, 0);
    run_cycles(600, 30, 50, 15, 5);
    run_cycles(400, 90, 20, 40, 0);
    run_cycles(400, 5, 60, 2, 0);
    run_cycles(300, 50, 100, 1, 10);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
